// File: rtl/univ_shift_reg_burst.sv
// Universal shift register: hold/shift/load/rotate/ASR plus an auto-burst right-shift engine.
// Optional build macro SHREG_PARITY_EN adds a registered parity output that always equals ^q.
module univ_shift_reg_burst #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic             busy,
`ifdef SHREG_PARITY_EN
    output logic             done,
    output logic             parity
`else
    output logic             done
`endif
);

    // state    | meaning
    // ST_IDLE  | executes mode each enabled cycle; mode 111 accepts a burst
    // ST_BURST | one right shift per enabled cycle until the counter reaches terminal count

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic [WIDTH-1:0] q_next;

    assign serial_out_r = q[0];
    assign serial_out_l = q[WIDTH-1];

    always_comb begin
        q_next = q;
        if (state == ST_BURST) begin
            q_next = {serial_in_r, q[WIDTH-1:1]};
        end else begin
            case (mode)
                3'b001:  q_next = {serial_in_r, q[WIDTH-1:1]};
                3'b010:  q_next = {q[WIDTH-2:0], serial_in_l};
                3'b011:  q_next = parallel_in;
                3'b100:  q_next = {q[0], q[WIDTH-1:1]};
                3'b101:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                3'b110:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
                default: q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            q         <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                q <= q_next;
                case (state)
                    ST_IDLE: begin
                        if (mode == 3'b111) begin
                            if (burst_len != '0) begin
                                burst_cnt <= burst_len;
                                state     <= ST_BURST;
                                busy      <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_BURST: begin
                        burst_cnt <= burst_cnt - 1'b1;
                        if (burst_cnt == CNT_W'(1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SHREG_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            parity <= 1'b0;
        end else if (en) begin
            parity <= ^q_next;
        end
    end
`endif

endmodule
